pkt_wr_ctrl: RTL

Drains the 32-bit capture FIFO filled by the read controller and writes each word to a host-visible memory buffer through an Avalon-MM write master. It sits directly downstream of the capture FIFO. It takes a base address and a word count from the control registers and reports completion through `wr_ctrl_rdy`; the read controller uses that signal to finish a transfer.

---
 rtl/pkt_wr_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pkt_wr_ctrl.sv
// pkt_wr_ctrl: drains the 32-bit capture FIFO and writes each word to a host
// memory buffer through an Avalon-MM write master.
//
// Optional feature: define PKT_WR_CTRL_BYTE_SWAP_EN to byte-reverse each FIFO word
// (network order to host order) as it is loaded. The default build writes the
// FIFO word unmodified.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start, abort          transfer request (IDLE only) / early termination level
//   base_addr, len_words  destination byte address ([1:0] ignored), word count
//   fifo_out, fifo_empty  FIFO read data (valid the cycle after fifo_rdreq), empty flag
//   fifo_rdreq            FIFO read strobe
//   avm_*                 Avalon-MM write master
//   busy                  high in any state other than IDLE
//   wr_ctrl_rdy           one-cycle completion pulse
//   words_written         words accepted by the slave in the current/last transfer
// All outputs are registered.
module pkt_wr_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len_words,
  input  logic [31:0]       fifo_out,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              wr_ctrl_rdy,
  output logic [LEN_W-1:0]  words_written
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWrite,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              write_q, write_d;
  logic              rdreq_q, rdreq_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [31:0]       load_word;

  // Low address bits are forced to zero, so they are intentionally unused.
  logic unused_base_bits;
  assign unused_base_bits = ^base_addr[1:0];

`ifdef PKT_WR_CTRL_BYTE_SWAP_EN
  assign load_word = {fifo_out[7:0], fifo_out[15:8], fifo_out[23:16], fifo_out[31:24]};
`else
  assign load_word = fifo_out;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    write_d     = write_q;
    rdreq_d     = 1'b0;
    rdy_d       = 1'b0;
    remaining_d = remaining_q;
    count_d     = count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = {base_addr[ADDR_W-1:2], 2'b00};
          remaining_d = len_words;
          count_d     = '0;
          if (len_words == '0) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
            // Read strobe is registered: issue it on FETCH entry when data is
            // already waiting, so FETCH takes a single cycle.
            rdreq_d = !fifo_empty && !abort;
          end
        end
      end

      StFetch: begin
        if (rdreq_q) begin
          // Read already committed this cycle; the word must be consumed.
          state_d = StLoad;
        end else if (abort) begin
          state_d = StDone;
          rdy_d   = 1'b1;
        end else if (!fifo_empty) begin
          rdreq_d = 1'b1;
        end
      end

      StLoad: begin
        data_d  = load_word;
        write_d = 1'b1;
        state_d = StWrite;
      end

      StWrite: begin
        if (!avm_waitrequest) begin
          write_d     = 1'b0;
          addr_d      = addr_q + ADDR_W'(4);
          remaining_d = remaining_q - LEN_W'(1);
          count_d     = (count_q == {LEN_W{1'b1}}) ? count_q : count_q + LEN_W'(1);
          if ((remaining_q == LEN_W'(1)) || abort) begin
            state_d = StDone;
            rdy_d   = 1'b1;
          end else begin
            state_d = StFetch;
            rdreq_d = !fifo_empty;
          end
        end
      end

      StDone: begin
        // Zero-length transfers enter DONE without the pulse armed; emit it
        // one cycle later so it lands two cycles after start.
        if (rdy_q) begin
          state_d = StIdle;
        end else begin
          rdy_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      rdreq_q     <= 1'b0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b0;
      remaining_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      write_q     <= write_d;
      rdreq_q     <= rdreq_d;
      busy_q      <= busy_d;
      rdy_q       <= rdy_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
    end
  end

  assign fifo_rdreq    = rdreq_q;
  assign avm_address   = addr_q;
  assign avm_write     = write_q;
  assign avm_writedata = data_q;
  assign busy          = busy_q;
  assign wr_ctrl_rdy   = rdy_q;
  assign words_written = count_q;

endmodule
